// File: rtl/dcache_dm_if.sv
// SLB request/response and MC data-port signals of the direct-mapped data cache.
// The cache takes the slave view; whatever drives SLB and MC takes the master view.
interface dcache_dm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NICK_W = 4,
    parameter int LEN_W  = 3
);
    logic              rdy;
    logic              clr;
    logic              req_en;
    logic              req_ls;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [LEN_W-1:0]  req_len;
    logic [NICK_W-1:0] req_nick;
    logic              req_ready;
    logic              resp_done;
    logic [DATA_W-1:0] resp_data;
    logic [NICK_W-1:0] resp_nick;
    logic              mc_en;
    logic              mc_ls;
    logic [ADDR_W-1:0] mc_addr;
    logic [DATA_W-1:0] mc_data;
    logic [LEN_W-1:0]  mc_len;
    logic              mc_busy;
    logic              mc_done;
    logic [DATA_W-1:0] mc_rdata;

    modport master (
        output rdy, clr, req_en, req_ls, req_addr, req_data, req_len, req_nick,
        input  req_ready, resp_done, resp_data, resp_nick,
        input  mc_en, mc_ls, mc_addr, mc_data, mc_len,
        output mc_busy, mc_done, mc_rdata
    );

    modport slave (
        input  rdy, clr, req_en, req_ls, req_addr, req_data, req_len, req_nick,
        output req_ready, resp_done, resp_data, resp_nick,
        output mc_en, mc_ls, mc_addr, mc_data, mc_len,
        input  mc_busy, mc_done, mc_rdata
    );
endinterface

// File: rtl/dcache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache between SLB and MC.
// Latency: load hit resp_done 2 cycles after accept; miss 3 cycles plus MC time.
// Backpressure: one request in flight, req_ready only in IDLE; mc_busy stalls issue.
module dcache_dm #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter int         NICK_W = 4,
    parameter int         LEN_W  = 3,
    parameter int         IDX_W  = 6,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input logic       clk,
    input logic       rst,
    dcache_dm_if.slave bus
);
    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic              ls;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
        logic [NICK_W-1:0] nick;
    } req_t;

    state_t            state;
    req_t              r;
    logic              hit_q;
    logic              killed;
    logic [DATA_W-1:0] rd_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES];

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [4:0]        sh;
    logic [DATA_W-1:0] len_mask;
    logic [DATA_W-1:0] line_rd;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] merged;
    logic              bypass;
    logic              hit;
    logic              arr_we;
    logic [DATA_W-1:0] arr_wd;

    assign idx     = r.addr[IDX_W+1:2];
    assign tag     = r.addr[ADDR_W-1:IDX_W+2];
    assign sh      = {r.addr[1:0], 3'b000};
    assign line_rd = data_arr[idx];
    assign wr_mask = len_mask << sh;
    assign merged  = (line_rd & ~wr_mask) | ((r.data << sh) & wr_mask);
    assign bypass  = (r.addr[17:16] == IO_HI)
                   || (r.len == LEN_W'(2) && r.addr[0])
                   || (r.len == LEN_W'(4) && r.addr[1:0] != 2'b00);
    assign hit     = !bypass && valid_q[idx] && (tag_arr[idx] == tag);

    // clr blocks acceptance in the same cycle so a flushed request never enters
    assign bus.req_ready = bus.rdy && (state == S_IDLE) && !bus.clr && !rst;

    always_comb begin
        case (r.len)
            LEN_W'(1): len_mask = DATA_W'(8'hFF);
            LEN_W'(2): len_mask = DATA_W'(16'hFFFF);
            default:   len_mask = '1;
        endcase
    end

    always_comb begin
        arr_we = 1'b0;
        arr_wd = bus.mc_rdata;
        if (state == S_WAIT && bus.mc_done) begin
            if (!r.ls && !bypass) begin
                arr_we = 1'b1;
            end else if (r.ls && hit_q) begin
                arr_we = 1'b1;
                arr_wd = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && arr_we) begin
            data_arr[idx] <= arr_wd;
            tag_arr[idx]  <= tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            r             <= '0;
            hit_q         <= 1'b0;
            killed        <= 1'b0;
            rd_q          <= '0;
            valid_q       <= '0;
            bus.resp_done <= 1'b0;
            bus.resp_data <= '0;
            bus.resp_nick <= '0;
            bus.mc_en     <= 1'b0;
            bus.mc_ls     <= 1'b0;
            bus.mc_addr   <= '0;
            bus.mc_data   <= '0;
            bus.mc_len    <= '0;
        end else if (bus.rdy) begin
            bus.resp_done <= 1'b0;
            bus.mc_en     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_en && bus.req_ready) begin
                        r.ls   <= bus.req_ls;
                        r.addr <= bus.req_addr;
                        r.data <= bus.req_data;
                        r.len  <= bus.req_len;
                        r.nick <= bus.req_nick;
                        killed <= 1'b0;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bus.clr && !r.ls) begin
                        state <= S_IDLE;
                    end else if (!r.ls && hit) begin
                        rd_q  <= (line_rd >> sh) & len_mask;
                        state <= S_RESP;
                    end else begin
                        hit_q <= hit;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.clr && !r.ls) begin
                        state <= S_IDLE;
                    end else if (!bus.mc_busy) begin
                        bus.mc_en   <= 1'b1;
                        bus.mc_ls   <= r.ls;
                        bus.mc_data <= r.ls ? r.data : '0;
                        if (!r.ls && !bypass) begin
                            bus.mc_addr <= {r.addr[ADDR_W-1:2], 2'b00};
                            bus.mc_len  <= LEN_W'(4);
                        end else begin
                            bus.mc_addr <= r.addr;
                            bus.mc_len  <= r.len;
                        end
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // a flushed load still waits for its fill; only the response is dropped
                    if (bus.mc_done) begin
                        if (!r.ls && !bypass) valid_q[idx] <= 1'b1;
                        if (r.ls)        rd_q <= '0;
                        else if (bypass) rd_q <= bus.mc_rdata & len_mask;
                        else             rd_q <= (bus.mc_rdata >> sh) & len_mask;
                        state <= (!r.ls && (killed || bus.clr)) ? S_IDLE : S_RESP;
                    end else if (bus.clr && !r.ls) begin
                        killed <= 1'b1;
                    end
                end
                S_RESP: begin
                    bus.resp_done <= !(bus.clr && !r.ls);
                    bus.resp_data <= rd_q;
                    bus.resp_nick <= r.nick;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_dm.sv
// Directed scoreboard bench for dcache_dm: stimulus pushes expected MC requests and
// responses, a negedge monitor pops and compares, and a small MC model answers requests.
module tb_dcache_dm;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_dm_if bus();
    dcache_dm dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] data;
        logic [3:0]  nick;
        int          acc;
        bit          chk_lat;
    } rexp_t;

    typedef struct {
        logic        ls;
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  len;
    } mexp_t;

    localparam int K_HIT = 0, K_MC = 1, K_MC_NORESP = 2, K_NONE = 3;

    rexp_t       rq[$];
    mexp_t       mq[$];
    rexp_t       re;
    mexp_t       me;
    logic [31:0] mem [int];
    int checks = 0, failures = 0;
    int cyc = 0, mc_cnt = 0, resp_cnt = 0, mc_lat = 2;
    logic mc_en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lmask(input logic [2:0] l);
        case (l)
            3'd1:    return 32'h0000_00FF;
            3'd2:    return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.resp_done) begin
                resp_cnt++;
                chk("resp expected", rq.size() != 0, 1);
                if (rq.size() != 0) begin
                    re = rq.pop_front();
                    chk("resp_data", bus.resp_data, re.data);
                    chk("resp_nick", bus.resp_nick, re.nick);
                    if (re.chk_lat) chk("hit latency", cyc - re.acc, 2);
                end
            end
            if (bus.mc_en) begin
                mc_cnt++;
                chk("mc_en expected", mq.size() != 0, 1);
                chk("mc_en while busy", bus.mc_busy, 0);
                chk("mc_en one-cycle", mc_en_prev, 0);
                if (mq.size() != 0) begin
                    me = mq.pop_front();
                    chk("mc_ls", bus.mc_ls, me.ls);
                    chk("mc_addr", bus.mc_addr, me.addr);
                    chk("mc_len", bus.mc_len, me.len);
                    if (me.ls) chk("mc_data", bus.mc_data, me.data);
                end
            end
            mc_en_prev = bus.mc_en;
        end
    end

    // MC model: word memory, LSB-aligned read data, done after mc_lat cycles
    initial begin
        logic [31:0] a, d, w, m;
        logic [2:0]  l;
        logic        s;
        int          k;
        bus.mc_done  = 1'b0;
        bus.mc_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.mc_en) begin
                a = bus.mc_addr; d = bus.mc_data; l = bus.mc_len; s = bus.mc_ls;
                repeat (mc_lat) @(negedge clk);
                k = int'(a >> 2);
                w = mem.exists(k) ? mem[k] : 32'h0;
                m = lmask(l) << (8 * a[1:0]);
                if (s) begin
                    mem[k] = (w & ~m) | ((d << (8 * a[1:0])) & m);
                    bus.mc_rdata = 32'hA5A5_A5A5;
                end else begin
                    bus.mc_rdata = (w >> (8 * a[1:0])) & lmask(l);
                end
                bus.mc_done = 1'b1;
                @(negedge clk);
                bus.mc_done = 1'b0;
            end
        end
    end

    task automatic send(input logic ls, input logic [31:0] addr, input logic [31:0] data,
                        input logic [2:0] len, input logic [3:0] nick, input logic [31:0] rdata,
                        input logic [31:0] maddr, input logic [2:0] mlen, input int kind);
        int g = 0;
        @(negedge clk);
        bus.req_en = 1'b1; bus.req_ls = ls; bus.req_addr = addr;
        bus.req_data = data; bus.req_len = len; bus.req_nick = nick;
        while (!bus.req_ready && g < 300) begin @(negedge clk); g++; end
        if (g >= 300) chk("accept timeout", bus.req_ready, 1);
        if (kind == K_MC || kind == K_MC_NORESP)
            mq.push_back('{ls: ls, addr: maddr, data: data, len: mlen});
        if (kind == K_HIT || kind == K_MC)
            rq.push_back('{data: rdata, nick: nick, acc: cyc + 1, chk_lat: kind == K_HIT});
        @(posedge clk);
        #1 bus.req_en = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((rq.size() != 0 || mq.size() != 0) && g < 300) begin @(negedge clk); g++; end
        chk("drain queues empty", rq.size() + mq.size(), 0);
        repeat (mc_lat + 6) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m0, r0;
        mem[32'h100 >> 2]   = 32'hDEAD_BEEF;
        mem[32'h200 >> 2]   = 32'h1122_3344;
        mem[32'h30000 >> 2] = 32'hCAFE_F00D;
        mem[32'h400 >> 2]   = 32'h0BAD_F00D;
        rst = 1'b1;
        bus.rdy = 1'b1; bus.clr = 1'b0; bus.mc_busy = 1'b0;
        bus.req_en = 1'b0; bus.req_ls = 1'b0; bus.req_addr = '0;
        bus.req_data = '0; bus.req_len = '0; bus.req_nick = '0;
        repeat (3) @(negedge clk);
        chk("req_ready in reset", bus.req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset resp_done", bus.resp_done, 0);
        chk("reset resp_data", bus.resp_data, 0);
        chk("reset resp_nick", bus.resp_nick, 0);
        chk("reset mc_en", bus.mc_en, 0);
        chk("reset mc_ls", bus.mc_ls, 0);
        chk("reset mc_addr", bus.mc_addr, 0);
        chk("reset mc_data", bus.mc_data, 0);
        chk("reset mc_len", bus.mc_len, 0);
        chk("req_ready after reset", bus.req_ready, 1);

        // fill, then hits on the same line
        send(0, 32'h100, 0, 3'd4, 4'd1, 32'hDEAD_BEEF, 32'h100, 3'd4, K_MC);   drain();
        send(0, 32'h100, 0, 3'd4, 4'd2, 32'hDEAD_BEEF, 0, 0, K_HIT);           drain();
        send(0, 32'h102, 0, 3'd1, 4'd3, 32'h0000_00AD, 0, 0, K_HIT);           drain();
        send(0, 32'h101, 0, 3'd2, 4'd4, 32'h0000_ADBE, 32'h101, 3'd2, K_MC);   drain();
        // store hit merges, store miss does not allocate
        send(1, 32'h103, 32'h55, 3'd1, 4'd5, 32'h0, 32'h103, 3'd1, K_MC);      drain();
        send(0, 32'h100, 0, 3'd4, 4'd6, 32'h55AD_BEEF, 0, 0, K_HIT);           drain();
        send(1, 32'h400, 32'h1234_5678, 3'd4, 4'd7, 32'h0, 32'h400, 3'd4, K_MC); drain();
        send(0, 32'h400, 0, 3'd4, 4'd8, 32'h1234_5678, 32'h400, 3'd4, K_MC);   drain();
        // IO space is never cached
        send(0, 32'h30000, 0, 3'd4, 4'd9, 32'hCAFE_F00D, 32'h30000, 3'd4, K_MC); drain();
        send(0, 32'h30000, 0, 3'd4, 4'd9, 32'hCAFE_F00D, 32'h30000, 3'd4, K_MC); drain();

        // mc_busy delays issue
        bus.mc_busy = 1'b1;
        m0 = mc_cnt;
        send(0, 32'h200, 0, 3'd4, 4'd10, 32'h1122_3344, 32'h200, 3'd4, K_MC);
        repeat (5) @(negedge clk);
        chk("no mc_en while busy", mc_cnt, m0);
        bus.mc_busy = 1'b0;
        drain();
        chk("mc_en after busy", mc_cnt, m0 + 1);

        // index conflict: 0x100 and 0x200 evict each other
        send(0, 32'h100, 0, 3'd4, 4'd11, 32'h55AD_BEEF, 32'h100, 3'd4, K_MC);  drain();
        send(0, 32'h200, 0, 3'd4, 4'd12, 32'h1122_3344, 32'h200, 3'd4, K_MC);  drain();
        send(0, 32'h100, 0, 3'd4, 4'd13, 32'h55AD_BEEF, 32'h100, 3'd4, K_MC);  drain();

        // clr during ISSUE cancels a load
        bus.mc_busy = 1'b1;
        m0 = mc_cnt; r0 = resp_cnt;
        send(0, 32'h500, 0, 3'd4, 4'd14, 0, 0, 0, K_NONE);
        repeat (2) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        bus.mc_busy = 1'b0;
        repeat (8) @(negedge clk);
        chk("clr ISSUE no mc_en", mc_cnt, m0);
        chk("clr ISSUE no resp", resp_cnt, r0);
        chk("clr ISSUE req_ready", bus.req_ready, 1);

        // clr during WAIT: store still completes, load fill happens silently
        mc_lat = 4;
        send(1, 32'h102, 32'hBEEF, 3'd2, 4'd15, 32'h0, 32'h102, 3'd2, K_MC);
        repeat (4) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        drain();
        send(0, 32'h100, 0, 3'd4, 4'd1, 32'hBEEF_BEEF, 0, 0, K_HIT);           drain();
        r0 = resp_cnt;
        send(0, 32'h200, 0, 3'd4, 4'd2, 0, 32'h200, 3'd4, K_MC_NORESP);
        repeat (4) @(negedge clk);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        drain();
        chk("clr WAIT load no resp", resp_cnt, r0);
        send(0, 32'h200, 0, 3'd4, 4'd3, 32'h1122_3344, 0, 0, K_HIT);           drain();
        mc_lat = 2;

        @(negedge clk);
        bus.rdy = 1'b0;
        @(negedge clk);
        chk("req_ready with rdy low", bus.req_ready, 0);
        bus.rdy = 1'b1;
        @(negedge clk);
        chk("req_ready with rdy high", bus.req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
